game_state_ctrl: RTL

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_pkg.sv | 15 +
 rtl/btn_edge.sv | 15 +
 rtl/game_state_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared game constants (state encoding, level/lives widths, timer width).
package game_pkg;
   localparam int LEVEL_W       = 4;
   localparam int LIVES_W       = 2;
   localparam int TIMER_W       = 25;
   localparam int MAX_LEVEL_DEF = 9;
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PLAY      = 3'd1,
      ST_DEATH     = 3'd2,
      ST_LEVEL_UP  = 3'd3,
      ST_GAME_OVER = 3'd4,
      ST_PAUSE     = 3'd5
   } state_t;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: rising-edge detector on a debounced button level.
// The history register resets high so a button held through reset yields no edge.
module btn_edge (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Btn,
   output logic o_Rise
);
   logic prev_q;
   always_ff @(posedge i_Clk) begin
      if (i_Rst) prev_q <= 1'b1;
      else       prev_q <= i_Btn;
   end
   assign o_Rise = i_Btn & ~prev_q;
endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: game FSM with move tick, death/level-up pauses, lives and level tracking.
// Define GAME_PAUSE_EN to enable the PLAY <-> PAUSE toggle on i_Pause.
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int TICK_DIV       = 2097152,
   parameter int DEATH_CYCLES   = 25000000,
   parameter int LEVELUP_CYCLES = 25000000,
   parameter int START_LIVES    = 3,
   parameter int MAX_LEVEL      = MAX_LEVEL_DEF
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   input  logic               i_Start,
   input  logic               i_Pause,
   input  logic               i_Collision,
   input  logic               i_Goal,
   output logic [2:0]         o_State,
   output logic               o_Move_En,
   output logic               o_Respawn,
   output logic [LEVEL_W-1:0] o_Level,
   output logic [LIVES_W-1:0] o_Lives,
   output logic               o_Game_Over
);
   localparam logic [TIMER_W-1:0] TICK_LAST  = TIMER_W'(TICK_DIV - 1);
   localparam logic [TIMER_W-1:0] DEATH_LAST = TIMER_W'(DEATH_CYCLES - 1);
   localparam logic [TIMER_W-1:0] LVL_LAST   = TIMER_W'(LEVELUP_CYCLES - 1);
   localparam logic [LEVEL_W-1:0] LVL_MAX    = LEVEL_W'(MAX_LEVEL);

   state_t               state_q;
   logic                 move_en_q, respawn_q, game_over_q;
   logic [LEVEL_W-1:0]   level_q;
   logic [LIVES_W-1:0]   lives_q;
   logic [TIMER_W-1:0]   tick_q, timer_q;
   logic                 start_rise, pause_rise;

   btn_edge u_start (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_Btn(i_Start), .o_Rise(start_rise));
`ifdef GAME_PAUSE_EN
   btn_edge u_pause (.i_Clk(i_Clk), .i_Rst(i_Rst), .i_Btn(i_Pause), .o_Rise(pause_rise));
`else
   logic unused_pause;
   assign unused_pause = i_Pause;
   assign pause_rise   = 1'b0;
`endif

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q     <= ST_IDLE;
         move_en_q   <= 1'b0;
         respawn_q   <= 1'b0;
         game_over_q <= 1'b0;
         level_q     <= LEVEL_W'(1);
         lives_q     <= '0;
         tick_q      <= '0;
         timer_q     <= '0;
      end else begin
         move_en_q <= 1'b0;
         respawn_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (start_rise) begin
               state_q   <= ST_PLAY;
               lives_q   <= LIVES_W'(START_LIVES);
               level_q   <= LEVEL_W'(1);
               respawn_q <= 1'b1;
               tick_q    <= '0;
            end
            ST_PLAY: if (i_Collision) begin
               state_q <= ST_DEATH;
               lives_q <= lives_q - LIVES_W'(1);
               timer_q <= '0;
            end else if (i_Goal) begin
               state_q <= ST_LEVEL_UP;
               level_q <= (level_q < LVL_MAX) ? level_q + LEVEL_W'(1) : level_q;
               timer_q <= '0;
            end else if (pause_rise) begin
               state_q <= ST_PAUSE;
            end else if (tick_q == TICK_LAST) begin
               tick_q    <= '0;
               move_en_q <= 1'b1;
            end else begin
               tick_q <= tick_q + TIMER_W'(1);
            end
            ST_DEATH: if (timer_q == DEATH_LAST) begin
               timer_q     <= '0;
               tick_q      <= '0;
               state_q     <= (lives_q == '0) ? ST_GAME_OVER : ST_PLAY;
               game_over_q <= (lives_q == '0);
               respawn_q   <= (lives_q != '0);
            end else begin
               timer_q <= timer_q + TIMER_W'(1);
            end
            ST_LEVEL_UP: if (timer_q == LVL_LAST) begin
               timer_q   <= '0;
               tick_q    <= '0;
               state_q   <= ST_PLAY;
               respawn_q <= 1'b1;
            end else begin
               timer_q <= timer_q + TIMER_W'(1);
            end
            ST_GAME_OVER: if (start_rise) begin
               state_q     <= ST_IDLE;
               game_over_q <= 1'b0;
            end
            // resume keeps the frozen tick count
            ST_PAUSE: if (pause_rise) state_q <= ST_PLAY;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_State     = state_q;
   assign o_Move_En   = move_en_q;
   assign o_Respawn   = respawn_q;
   assign o_Level     = level_q;
   assign o_Lives     = lives_q;
   assign o_Game_Over = game_over_q;
endmodule
